// File: rtl/menu_select_ctrl_if.sv
// Menu controller bus: cursor/button inputs, hover flags and the level-select handshake.
// master drives the cursor/menu side and level_ready; slave is the controller.
interface menu_select_ctrl_if;
    logic       menu_active;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       mouse_left;
    logic [1:0] unlocked;
    logic       level_ready;
    logic       mouseInLevel1;
    logic       mouseInLevel2;
    logic       mouseInLevel3;
    logic [1:0] level_sel;
    logic       level_valid;

    modport master (
        output menu_active, mouse_x, mouse_y, mouse_left, unlocked, level_ready,
        input  mouseInLevel1, mouseInLevel2, mouseInLevel3, level_sel, level_valid
    );

    modport slave (
        input  menu_active, mouse_x, mouse_y, mouse_left, unlocked, level_ready,
        output mouseInLevel1, mouseInLevel2, mouseInLevel3, level_sel, level_valid
    );
endinterface

// File: rtl/menu_select_ctrl.sv
// Menu-screen input controller: registered hover flags, debounced click detection and level-select request.
// Optional macro LEVEL_LOCK_EN restricts selectable/highlighted buttons to those <= unlocked.
module menu_select_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input logic               clk,
    input logic               rst,
    menu_select_ctrl_if.slave bus
);
    localparam int unsigned COORD_W = 10;
    localparam int unsigned N_BTN   = 3;

    localparam logic [COORD_W-1:0] X_LO  = COORD_W'(160);
    localparam logic [COORD_W-1:0] X_HI  = COORD_W'(480);
    localparam logic [COORD_W-1:0] Y1_LO = COORD_W'(80);
    localparam logic [COORD_W-1:0] Y1_HI = COORD_W'(140);
    localparam logic [COORD_W-1:0] Y2_LO = COORD_W'(200);
    localparam logic [COORD_W-1:0] Y2_HI = COORD_W'(260);
    localparam logic [COORD_W-1:0] Y3_LO = COORD_W'(320);
    localparam logic [COORD_W-1:0] Y3_HI = COORD_W'(380);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PRESSED,
        ST_REQ
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              btn_db_q, btn_db_d;
    logic [N_BTN-1:0]  hover_q, hover_d;
    logic              valid_q, valid_d;
    logic [1:0]        level_sel_q, level_sel_d;

    logic              in_x_c;
    logic [N_BTN-1:0]  raw_hit_c;
    logic [N_BTN-1:0]  sel_en_c;
    logic [N_BTN-1:0]  hit_c;
    logic [1:0]        hit_idx_c;
    logic              sel_hit_c;
    logic              differ_c;
    logic              db_toggle_c;
    logic              db_rise_c;
    logic              db_fall_c;

    // Half-open button regions sharing one x span.
    always_comb begin
        in_x_c       = (bus.mouse_x >= X_LO) && (bus.mouse_x < X_HI);
        raw_hit_c[0] = in_x_c && (bus.mouse_y >= Y1_LO) && (bus.mouse_y < Y1_HI);
        raw_hit_c[1] = in_x_c && (bus.mouse_y >= Y2_LO) && (bus.mouse_y < Y2_HI);
        raw_hit_c[2] = in_x_c && (bus.mouse_y >= Y3_LO) && (bus.mouse_y < Y3_HI);
    end

`ifdef LEVEL_LOCK_EN
    logic [1:0] unl_eff_c;
    // unlocked=0 behaves as level 1 unlocked.
    always_comb begin
        unl_eff_c = (bus.unlocked == 2'd0) ? 2'd1 : bus.unlocked;
        sel_en_c  = {unl_eff_c == 2'd3, unl_eff_c >= 2'd2, 1'b1};
    end
`else
    logic unused_unlocked;
    assign unused_unlocked = ^bus.unlocked;
    assign sel_en_c        = {N_BTN{1'b1}};
`endif

    always_comb begin
        hit_c = raw_hit_c & sel_en_c;
        if (hit_c[0])      hit_idx_c = 2'd1;
        else if (hit_c[1]) hit_idx_c = 2'd2;
        else if (hit_c[2]) hit_idx_c = 2'd3;
        else               hit_idx_c = 2'd0;
        case (sel_q)
            2'd1:    sel_hit_c = hit_c[0];
            2'd2:    sel_hit_c = hit_c[1];
            2'd3:    sel_hit_c = hit_c[2];
            default: sel_hit_c = 1'b0;
        endcase
    end

    // Debounce: the new level must persist DEBOUNCE_CYCLES samples before it is taken.
    always_comb begin
        differ_c    = (bus.mouse_left != btn_db_q);
        db_toggle_c = differ_c && (cnt_q == CNT_LAST);
        cnt_d       = (differ_c && !db_toggle_c) ? cnt_q + CNT_W'(1) : '0;
        btn_db_d    = btn_db_q ^ db_toggle_c;
        db_rise_c   = db_toggle_c && !btn_db_q;
        db_fall_c   = db_toggle_c && btn_db_q;
    end

    // Click FSM next-state and registered-output values.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        hover_d     = hit_c & {N_BTN{bus.menu_active}};
        valid_d     = 1'b0;
        level_sel_d = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.menu_active && !btn_db_q) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!bus.menu_active) begin
                    state_d = ST_IDLE;
                end else if (db_rise_c && (hit_idx_c != 2'd0)) begin
                    sel_d   = hit_idx_c;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!bus.menu_active) begin
                    state_d = ST_IDLE;
                end else if (db_fall_c) begin
                    state_d = sel_hit_c ? ST_REQ : ST_ARMED;
                end
            end
            ST_REQ: begin
                // A pending request survives menu exit; only the handshake retires it.
                if (valid_q && bus.level_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_REQ) begin
            valid_d     = 1'b1;
            level_sel_d = sel_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            cnt_q       <= '0;
            btn_db_q    <= 1'b0;
            hover_q     <= '0;
            valid_q     <= 1'b0;
            level_sel_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            btn_db_q    <= btn_db_d;
            hover_q     <= hover_d;
            valid_q     <= valid_d;
            level_sel_q <= level_sel_d;
        end
    end

    assign bus.mouseInLevel1 = hover_q[0];
    assign bus.mouseInLevel2 = hover_q[1];
    assign bus.mouseInLevel3 = hover_q[2];
    assign bus.level_valid   = valid_q;
    assign bus.level_sel     = level_sel_q;

endmodule

// File: tb/tb_menu_select_ctrl.sv
// Scoreboard bench for menu_select_ctrl: a cycle reference model pushes expected outputs, a negedge monitor checks them.
module tb_menu_select_ctrl;
    localparam int DEB = 4;
    localparam int M_IDLE = 0, M_ARMED = 1, M_PRESSED = 2, M_REQ = 3;

    typedef struct packed {
        logic [2:0] hover;
        logic       valid;
        logic [1:0] sel;
    } exp_t;

    logic clk;
    logic rst;
    menu_select_ctrl_if bus();

    menu_select_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_got;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   req_seen = 0;
    int   rdy_pct = 0;
    int   cur_x = 0, cur_y = 0;

    // Reference model state: click progress, debounced button, run of differing samples.
    int m_mode, m_sel, m_run;
    bit m_db;

    function automatic int region(int x, int y);
        if (x < 160 || x >= 480) return 0;
        if (y >= 80  && y < 140) return 1;
        if (y >= 200 && y < 260) return 2;
        if (y >= 320 && y < 380) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_sel = 0; m_run = 0; m_db = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently on the bus.
    task automatic apply();
        int   hit;
        bit   old_db, rise, fall;
        exp_t e;
        hit = region(int'(bus.mouse_x), int'(bus.mouse_y));
`ifdef LEVEL_LOCK_EN
        begin
            int eff;
            eff = (bus.unlocked == 2'd0) ? 1 : int'(bus.unlocked);
            if (hit > eff) hit = 0;
        end
`endif
        old_db = m_db;
        if (bus.mouse_left != m_db) m_run++; else m_run = 0;
        if (m_run == DEB) begin m_db = bus.mouse_left; m_run = 0; end
        rise = !old_db && m_db;
        fall = old_db && !m_db;
        case (m_mode)
            M_IDLE:    if (bus.menu_active && !old_db) m_mode = M_ARMED;
            M_ARMED:   if (!bus.menu_active) m_mode = M_IDLE;
                       else if (rise && hit != 0) begin m_sel = hit; m_mode = M_PRESSED; end
            M_PRESSED: if (!bus.menu_active) m_mode = M_IDLE;
                       else if (fall) m_mode = (hit == m_sel) ? M_REQ : M_ARMED;
            default:   if (bus.level_ready) m_mode = M_IDLE;
        endcase
        e.hover = (bus.menu_active && hit != 0) ? 3'(1 << (hit - 1)) : 3'b000;
        e.valid = (m_mode == M_REQ);
        e.sel   = e.valid ? 2'(m_sel) : 2'd0;
        exp_q.push_back(e);
    endtask

    task automatic drive(int x, int y, bit ml, bit act, int n);
        repeat (n) begin
            @(negedge clk); #1;
            cur_x = x; cur_y = y;
            bus.mouse_x     = 10'(x);
            bus.mouse_y     = 10'(y);
            bus.mouse_left  = ml;
            bus.menu_active = act;
            bus.level_ready = ($urandom_range(99) < rdy_pct);
            apply();
        end
    endtask

    task automatic click(int x, int y, int hold, int gap);
        drive(x, y, 1'b1, 1'b1, hold);
        drive(x, y, 1'b0, 1'b1, gap);
    endtask

    // Hold ready low until the model is requesting, then 5 more cycles, then accept.
    task automatic wait_req_and_ack();
        int k = 0;
        rdy_pct = 0;
        while (m_mode != M_REQ && k < 30) begin
            drive(cur_x, cur_y, 1'b0, 1'b1, 1);
            k++;
        end
        n_tests++;
        if (k >= 30) begin
            n_fail++;
            $display("FAIL wait_req: model never reached a request within %0d cycles", k);
        end
        drive(cur_x, cur_y, 1'b0, 1'b1, 5);
        rdy_pct = 100;
        drive(cur_x, cur_y, 1'b0, 1'b1, 1);
        rdy_pct = 0;
        drive(cur_x, cur_y, 1'b0, 1'b1, 3);
    endtask

    task automatic check_zero(string tag, bit hover_only);
        logic [5:0] got;
        got = {bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1,
               hover_only ? 1'b0 : bus.level_valid, hover_only ? 2'd0 : bus.level_sel};
        n_tests++;
        if (got !== 6'd0) begin
            n_fail++;
            $display("FAIL %s: got hover/valid/sel=%b required 000000", tag, got);
        end
    endtask

    // Assert reset asynchronously mid-cycle, then release it with the cursor over button 3.
    task automatic reset_mid_cycle();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async", 1'b0);
        model_reset();
        @(negedge clk); #1;
        bus.mouse_x = 10'd300; bus.mouse_y = 10'd350; cur_x = 300; cur_y = 350;
        bus.menu_active = 1'b1; bus.mouse_left = 1'b0; bus.level_ready = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("rst_release_hover", 1'b1);
        apply();
    endtask

    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1,
                       bus.level_valid, bus.level_sel};
            n_tests++;
            if (mon_got !== mon_e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got hover=%b valid=%b sel=%0d, required hover=%b valid=%b sel=%0d",
                         $time, mon_got.hover, mon_got.valid, mon_got.sel,
                         mon_e.hover, mon_e.valid, mon_e.sel);
            end
            if (mon_got.valid && mon_e.valid) req_seen++;
        end
    end

    function automatic void pick(output int x, output int y);
        case ($urandom_range(11))
            0:  begin x = 200; y = 100; end
            1:  begin x = 300; y = 230; end
            2:  begin x = 479; y = 379; end
            3:  begin x = 160; y = 80;  end
            4:  begin x = 480; y = 100; end
            5:  begin x = 159; y = 230; end
            6:  begin x = 300; y = 140; end
            7:  begin x = 300; y = 199; end
            8:  begin x = 100; y = 100; end
            9:  begin x = 350; y = 320; end
            10: begin x = 479; y = 259; end
            default: begin x = int'($urandom_range(639)); y = int'($urandom_range(479)); end
        endcase
    endfunction

    initial begin
        int x, y, x2, y2, hold, gap;
        bit act;
        rst = 1'b1;
        bus.menu_active = 1'b0; bus.mouse_x = '0; bus.mouse_y = '0;
        bus.mouse_left = 1'b0; bus.unlocked = 2'd3; bus.level_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_zero("reset_state", 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        apply();

        // Hover tracking and boundaries.
        drive(200, 100, 1'b0, 1'b1, 2);
        drive(200, 140, 1'b0, 1'b1, 2);
        drive(479, 379, 1'b0, 1'b1, 2);

        // Full click on button 2 held by a slow consumer.
        drive(300, 230, 1'b1, 1'b1, 10);
        wait_req_and_ack();

        // Glitch, drag-off cancel, drag-on press.
        click(200, 100, 2, 8);
        drive(200, 100, 1'b1, 1'b1, 6);
        drive(100, 100, 1'b1, 1'b1, 2);
        drive(100, 100, 1'b0, 1'b1, 8);
        drive(100, 100, 1'b1, 1'b1, 6);
        drive(200, 100, 1'b1, 1'b1, 2);
        drive(200, 100, 1'b0, 1'b1, 8);

        // Button held while the menu appears, then a genuine click on button 3.
        drive(300, 350, 1'b0, 1'b0, 3);
        drive(300, 350, 1'b1, 1'b0, 6);
        drive(300, 350, 1'b1, 1'b1, 4);
        drive(300, 350, 1'b0, 1'b1, 8);
        drive(300, 350, 1'b1, 1'b1, 6);
        wait_req_and_ack();

        // Reset while a request is pending.
        drive(300, 230, 1'b1, 1'b1, 6);
        drive(300, 230, 1'b0, 1'b1, DEB + 2);
        reset_mid_cycle();
        drive(300, 350, 1'b0, 1'b1, 3);

`ifdef LEVEL_LOCK_EN
        bus.unlocked = 2'd1;
        drive(300, 230, 1'b0, 1'b1, 3);
        click(300, 230, 6, 8);
        drive(200, 100, 1'b1, 1'b1, 6);
        wait_req_and_ack();
        bus.unlocked = 2'd0;
        click(300, 350, 6, 8);
`endif

        // Randomised clicks, drags, menu exits and ready patterns.
        rdy_pct = 30;
        for (int i = 0; i < 150; i++) begin
            bus.unlocked = 2'($urandom_range(3));
            pick(x, y);
            act  = ($urandom_range(9) != 0);
            hold = int'($urandom_range(1, 10));
            gap  = int'($urandom_range(1, 10));
            drive(x, y, 1'b1, act, hold);
            if ($urandom_range(3) == 0) begin
                pick(x2, y2);
                x = x2; y = y2;
                drive(x, y, 1'b1, act, int'($urandom_range(1, 3)));
            end
            drive(x, y, 1'b0, act, gap);
        end
        rdy_pct = 100;
        drive(100, 100, 1'b0, 1'b1, 4);
        @(negedge clk); #1;

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        n_tests++;
        if (req_seen == 0) begin
            n_fail++;
            $display("FAIL req_seen: got %0d request cycles, required nonzero", req_seen);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
